moore_pattern_detector: RTL and testbench

//  Parametrised Moore-style serial pattern detector. Generalises the fixed 1100 detector:
//  PAT_LEN-bit pattern, runtime loadable, overlap mode selectable, saturating match counter.

---
 rtl/patdet_pkg.sv | 27 ++
 rtl/patdet_sat_counter.sv | 42 ++++
 rtl/moore_pattern_detector.sv | 124 ++++++++++++
 tb/tb_moore_pattern_detector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/patdet_pkg.sv
// ============================================================================
// Module      : patdet_pkg
// Description : Shared state encoding and helpers for the Moore pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package patdet_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FILL  = 2'd0,
    S_SCAN  = 2'd1,
    S_MATCH = 2'd2
  } patdet_state_t;

  // Masked window compare: a zero mask bit excludes that position.
  function automatic logic window_hit(input logic [31:0] hist,
                                      input logic [31:0] pattern,
                                      input logic [31:0] mask);
    return ((hist ^ pattern) & mask) == 32'd0;
  endfunction

endpackage : patdet_pkg

`default_nettype wire

// File: rtl/patdet_sat_counter.sv
// ============================================================================
// Module      : patdet_sat_counter
// Description : Saturating up-counter with clear; clear plus increment yields 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module patdet_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(inc);
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule : patdet_sat_counter

`default_nettype wire

// File: rtl/moore_pattern_detector.sv
// ============================================================================
// Module      : moore_pattern_detector
// Description : Moore serial pattern detector with loadable pattern, selectable
//               overlap and saturating match counter.
//               Define PATDET_MASK_EN to add a loadable don't-care mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_pattern_detector
  import patdet_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               x,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
`ifdef PATDET_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  patdet_state_t       state_q, state_d;
  logic [PAT_LEN-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [PAT_LEN-1:0]  pattern_q, pattern_d;
  logic [PAT_LEN-1:0]  mask_w;

  logic [PAT_LEN-1:0]  hist_n;
  logic [FILL_W-1:0]   fill_n;
  logic                hit;

`ifdef PATDET_MASK_EN
  logic [PAT_LEN-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else if (pat_load) begin
      mask_q <= pat_mask_in;
    end
  end

  assign mask_w = mask_q;
`else
  assign mask_w = '1;
`endif

  assign hist_n = {hist_q[PAT_LEN-2:0], x};
  assign fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    hit       = 1'b0;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (in_valid) begin
      hit    = (fill_n == FILL_FULL) &&
               window_hit(32'(hist_n), 32'(pattern_q), 32'(mask_w));
      hist_d = hist_n;
      fill_d = fill_n;
      if (hit) begin
        state_d = S_MATCH;
        // Without overlap the next match must be built from fresh bits only.
        if (!OVERLAP) begin
          hist_d = '0;
          fill_d = '0;
        end
      end else if (fill_n < FILL_FULL) begin
        state_d = S_FILL;
      end else begin
        state_d = S_SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= PATTERN;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
    end
  end

  assign z = (state_q == S_MATCH);

  patdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (count_clr),
    .q   (match_count)
  );

endmodule : moore_pattern_detector

`default_nettype wire

// File: tb/tb_moore_pattern_detector.sv
// ============================================================================
// Module      : tb_moore_pattern_detector
// Description : Scoreboard bench for moore_pattern_detector (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moore_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [3:0] mask_in = 4'b1111;
  logic [1:0] iv = 2'b00;
  logic [1:0] pl = 2'b00;
  logic [1:0] cc = 2'b00;
  logic       za, zb;
  logic [7:0] ca;
  logic [1:0] cb;

  always #5 clk = ~clk;

  // A: default pattern 1100, overlap on, 8-bit counter.
  moore_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b1100), .OVERLAP (1'b1), .CNT_W (8)
  ) dut_a (
    .clk (clk), .rst (rst), .in_valid (iv[0]), .x (x),
    .pat_load (pl[0]), .pat_in (pat_in),
`ifdef PATDET_MASK_EN
    .pat_mask_in (mask_in),
`endif
    .count_clr (cc[0]), .z (za), .match_count (ca)
  );

  // B: pattern 1010, overlap off, 2-bit counter for saturation.
  moore_pattern_detector #(
    .PAT_LEN (4), .PATTERN (4'b1010), .OVERLAP (1'b0), .CNT_W (2)
  ) dut_b (
    .clk (clk), .rst (rst), .in_valid (iv[1]), .x (x),
    .pat_load (pl[1]), .pat_in (pat_in),
`ifdef PATDET_MASK_EN
    .pat_mask_in (mask_in),
`endif
    .count_clr (cc[1]), .z (zb), .match_count (cb)
  );

  typedef struct {
    int         sel;
    logic       ez;
    logic [7:0] ec;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: each cycle's expected outputs are compared one cycle after issue.
  initial begin
    exp_t       e;
    logic       act_z;
    logic [7:0] act_c;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e     = sbq.pop_front();
        act_z = (e.sel == 0) ? za : zb;
        act_c = (e.sel == 0) ? ca : {6'b000000, cb};
        checks++;
        if (act_z !== e.ez) begin
          errors++;
          $display("FAIL %s z: got %b expected %b", e.tag, act_z, e.ez);
        end
        checks++;
        if (act_c !== e.ec) begin
          errors++;
          $display("FAIL %s match_count: got %0d expected %0d", e.tag, act_c, e.ec);
        end
      end
    end
  end

  task automatic step(input int s, input logic r, input logic v, input logic xb,
                      input logic ld, input logic [3:0] pin, input logic clr,
                      input logic ez, input logic [7:0] ec, input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    rst    = r;
    iv     = 2'b00;
    pl     = 2'b00;
    cc     = 2'b00;
    iv[s]  = v;
    pl[s]  = ld;
    cc[s]  = clr;
    x      = xb;
    pat_in = pin;
    e.sel = s; e.ez = ez; e.ec = ec; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic do_rst(input int s, input string tag);
    step(s, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, tag);
  endtask

  task automatic bit_in(input int s, input logic xb, input logic ez,
                        input logic [7:0] ec, input string tag);
    step(s, 1'b0, 1'b1, xb, 1'b0, 4'b0000, 1'b0, ez, ec, tag);
  endtask

  task automatic idle(input int s, input int n, input logic ez,
                      input logic [7:0] ec, input string tag);
    for (int i = 0; i < n; i++)
      step(s, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, ez, ec, tag);
  endtask

  // Bits in a string of '0'/'1' chars, with expected z and count per bit.
  task automatic stream(input int s, input string bits, input string zs,
                        input logic [7:0] cnts[], input string tag);
    for (int i = 0; i < bits.len(); i++)
      bit_in(s, bits[i] == "1", zs[i] == "1", cnts[i], tag);
  endtask

  initial begin
    // Reset state
    do_rst(0, "reset_a");
    do_rst(0, "reset_a2");

    // Default pattern 1100
    stream(0, "1100", "0001", '{8'd0, 8'd0, 8'd0, 8'd1}, "basic_1100");
    idle(0, 1, 1'b1, 8'd1, "basic_hold");
    bit_in(0, 1'b1, 1'b0, 8'd1, "basic_drop");

    // Valid gaps: z and count hold while in_valid is low
    do_rst(0, "gap_rst");
    bit_in(0, 1'b1, 1'b0, 8'd0, "gap_b1");
    idle(0, 3, 1'b0, 8'd0, "gap_idle1");
    bit_in(0, 1'b1, 1'b0, 8'd0, "gap_b2");
    idle(0, 3, 1'b0, 8'd0, "gap_idle2");
    bit_in(0, 1'b0, 1'b0, 8'd0, "gap_b3");
    idle(0, 3, 1'b0, 8'd0, "gap_idle3");
    bit_in(0, 1'b0, 1'b1, 8'd1, "gap_b4");
    idle(0, 3, 1'b1, 8'd1, "gap_zhold");

    // Overlapping 1010 matches, loaded together with a counter clear
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 8'd0, "ovl_load");
    stream(0, "101010", "000101", '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2}, "ovl_1010");

    // pat_load wins over a coincident valid bit
    do_rst(0, "load_rst");
    stream(0, "110", "000", '{8'd0, 8'd0, 8'd0}, "load_pre");
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 8'd0, "load_0110");
    stream(0, "0110", "0001", '{8'd0, 8'd0, 8'd0, 8'd1}, "load_match");
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 8'd1, "load_again");
    stream(0, "110", "000", '{8'd1, 8'd1, 8'd1}, "load_discard");

    // Reset mid-stream, then counter clear behaviour
    do_rst(0, "mid_rst1");
    stream(0, "110", "000", '{8'd0, 8'd0, 8'd0}, "mid_pre");
    do_rst(0, "mid_rst2");
    bit_in(0, 1'b0, 1'b0, 8'd0, "mid_post");
    stream(0, "1100", "0001", '{8'd0, 8'd0, 8'd0, 8'd1}, "mid_rematch");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'd0, "clr_only");
    stream(0, "110", "000", '{8'd0, 8'd0, 8'd0}, "clr_pre");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'd1, "clr_with_match");
    bit_in(0, 1'b1, 1'b0, 8'd1, "clr_after");
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 8'd1, "load_keeps_cnt");

`ifdef PATDET_MASK_EN
    // Mask 1001: middle two bits are don't-care
    do_rst(0, "mask_rst");
    mask_in = 4'b1001;
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 8'd0, "mask_load");
    stream(0, "1010", "0001", '{8'd0, 8'd0, 8'd0, 8'd1}, "mask_match");
    mask_in = 4'b1111;
`endif

    // Non-overlap and saturation on the 2-bit counter
    do_rst(1, "b_reset");
    stream(1, "101010", "000100", '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1}, "b_novl");
    stream(1, "10", "01", '{8'd1, 8'd2}, "b_second");
    stream(1, "1010", "0001", '{8'd2, 8'd2, 8'd2, 8'd3}, "b_third");
    stream(1, "1010", "0001", '{8'd3, 8'd3, 8'd3, 8'd3}, "b_saturate");
    idle(1, 2, 1'b1, 8'd3, "b_hold");

    begin : drain
      int budget;
      budget = 20;
      while (sbq.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #2;
      if (sbq.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_moore_pattern_detector

`default_nettype wire
